// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL loop controller: PFD state encoding,
// phase-error saturation limit and a generic clamp used by the PI filter.
package adpll_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_AHEAD = 2'd1,
        FB_AHEAD  = 2'd2
    } pfd_state_e;

    localparam int DEF_ERR_WIDTH = 8;

    // Largest magnitude a signed error of the given width carries; the skew
    // counter saturates here and a missing edge reports this value.
    function automatic int err_max(input int err_width);
        return (1 << (err_width - 1)) - 1;
    endfunction

    localparam int DEF_ERR_MAX = err_max(DEF_ERR_WIDTH);

    // Saturate v into [lo, hi]; the control code must never wrap.
    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous clock input followed by an edge
// flop; emits a one-cycle pulse on each synchronised rising edge.
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic pulse_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;

    // Shift the raw input through the synchroniser and keep the previous level.
    always_comb begin
        sync1_d = d_i;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    // Synchroniser and edge flops.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    assign pulse_o = sync2_q & ~edge_q;

endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: digital PFD measuring reference/feedback edge skew in
// fpga_clk_i cycles, a PI loop filter producing the DCO control code, and a
// lock detector.
module adpll_loop_ctrl
    import adpll_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_WIDTH = 8,
    parameter int KP_SHIFT  = 2,
    parameter int KI_SHIFT  = 3,
    parameter int K_INIT    = 8,
    parameter int K_MIN     = 1,
    parameter int K_MAX     = 15,
    parameter int LOCK_TOL  = 2,
    parameter int LOCK_CNT  = 16
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             ref_clk_i,
    input  logic             fb_clk_i,
    output logic [WIDTH-1:0] k_val_o,
    output logic             dco_en_o,
    output logic             locked_o
);

    localparam int CNT_W = ERR_WIDTH - 1;
    localparam int SUM_W = WIDTH + ERR_WIDTH + 1;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic        [CNT_W-1:0]     CNT_MAX     = CNT_W'(err_max(ERR_WIDTH));
    localparam logic signed [ERR_WIDTH-1:0] ERR_POS_MAX = ERR_WIDTH'(err_max(ERR_WIDTH));
    localparam logic signed [ERR_WIDTH-1:0] ERR_NEG_MAX = -ERR_POS_MAX;
    localparam logic        [LCK_W-1:0]     LOCK_FULL   = LCK_W'(LOCK_CNT);

    logic ref_p, fb_p;

    pfd_state_e                   state_q, state_d;
    logic        [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic signed [ERR_WIDTH-1:0]  err_q, err_d, cnt_err;
    logic                         upd_q, upd_d;

    logic        [WIDTH-1:0]      integ_q, integ_d, integ_new;
    logic        [WIDTH-1:0]      k_val_q, k_val_d;
    logic signed [SUM_W-1:0]      err_ext, integ_sum, k_sum;

    logic        [ERR_WIDTH-1:0]  err_abs;
    logic                         in_tol;
    logic        [LCK_W-1:0]      lock_ctr_q, lock_ctr_d;
    logic                         locked_q, locked_d;
    logic                         dco_en_q, dco_en_d;

    edge_sync u_ref_sync (.clk_i(fpga_clk_i), .rst_i(reset_i), .d_i(ref_clk_i), .pulse_o(ref_p));
    edge_sync u_fb_sync  (.clk_i(fpga_clk_i), .rst_i(reset_i), .d_i(fb_clk_i),  .pulse_o(fb_p));

    // PFD next state: track which edge arrived first and emit a skew update.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = '0;
        upd_d   = 1'b0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cnt_err = signed'({1'b0, cnt_q});
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ref_p && fb_p) begin
                        upd_d = 1'b1;
                    end else if (ref_p) begin
                        state_d = REF_AHEAD;
                        cnt_d   = CNT_W'(1);
                    end else if (fb_p) begin
                        state_d = FB_AHEAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
                REF_AHEAD: begin
                    if (fb_p) begin
                        upd_d   = 1'b1;
                        err_d   = cnt_err;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (ref_p) begin
                        // Second reference edge before any feedback: frequency error.
                        upd_d = 1'b1;
                        err_d = ERR_POS_MAX;
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                FB_AHEAD: begin
                    if (ref_p) begin
                        upd_d   = 1'b1;
                        err_d   = -cnt_err;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (fb_p) begin
                        upd_d = 1'b1;
                        err_d = ERR_NEG_MAX;
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // PFD state, skew counter and registered update strobe.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
        end
    end

    // PI filter: integrator and output code, both saturated to [K_MIN, K_MAX].
    always_comb begin
        err_ext   = SUM_W'(err_q);
        integ_sum = signed'(SUM_W'(integ_q)) + (err_ext >>> KI_SHIFT);
        integ_new = WIDTH'(clamp(int'(integ_sum), K_MIN, K_MAX));
        k_sum     = signed'(SUM_W'(integ_new)) + (err_ext >>> KP_SHIFT);
        integ_d   = integ_q;
        k_val_d   = k_val_q;
        if (enable_i && upd_q) begin
            integ_d = integ_new;
            k_val_d = WIDTH'(clamp(int'(k_sum), K_MIN, K_MAX));
        end
    end

    // Lock detector: count consecutive in-tolerance updates, drop on any miss.
    always_comb begin
        err_abs    = err_q[ERR_WIDTH-1] ? $unsigned(-err_q) : $unsigned(err_q);
        in_tol     = (err_abs <= ERR_WIDTH'(LOCK_TOL));
        lock_ctr_d = lock_ctr_q;
        locked_d   = locked_q;
        dco_en_d   = enable_i;
        if (!enable_i) begin
            lock_ctr_d = '0;
            locked_d   = 1'b0;
        end else if (upd_q) begin
            if (in_tol) begin
                lock_ctr_d = (lock_ctr_q == LOCK_FULL) ? lock_ctr_q : lock_ctr_q + 1'b1;
            end else begin
                lock_ctr_d = '0;
            end
            locked_d = (lock_ctr_d == LOCK_FULL);
        end
    end

    // Filter, lock and DCO-enable registers.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            integ_q    <= WIDTH'(K_INIT);
            k_val_q    <= WIDTH'(K_INIT);
            lock_ctr_q <= '0;
            locked_q   <= 1'b0;
            dco_en_q   <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            k_val_q    <= k_val_d;
            lock_ctr_q <= lock_ctr_d;
            locked_q   <= locked_d;
            dco_en_q   <= dco_en_d;
        end
    end

    assign k_val_o  = k_val_q;
    assign locked_o = locked_q;
    assign dco_en_o = dco_en_q;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Self-checking bench for adpll_loop_ctrl. Drives reference/feedback edge pairs
// with known skews and compares k_val_o / locked_o / dco_en_o against an
// arithmetic model of the PI filter and lock rule.
module tb_adpll_loop_ctrl;

    localparam int WIDTH    = 4;
    localparam int KP_SHIFT = 2;
    localparam int KI_SHIFT = 3;
    localparam int K_INIT   = 8;
    localparam int K_MIN    = 1;
    localparam int K_MAX    = 15;
    localparam int LOCK_TOL = 2;
    localparam int LOCK_CNT = 16;
    localparam int E_MAX    = 127;

    logic             fpga_clk_i = 1'b0;
    logic             reset_i    = 1'b1;
    logic             enable_i   = 1'b1;
    logic             ref_clk_i  = 1'b0;
    logic             fb_clk_i   = 1'b0;
    logic [WIDTH-1:0] k_val_o;
    logic             dco_en_o;
    logic             locked_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_integ    = K_INIT;
    int m_k        = K_INIT;
    int m_lock_run = 0;
    int m_locked   = 0;

    always #5 fpga_clk_i = ~fpga_clk_i;

    adpll_loop_ctrl dut (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .ref_clk_i  (ref_clk_i),
        .fb_clk_i   (fb_clk_i),
        .k_val_o    (k_val_o),
        .dco_en_o   (dco_en_o),
        .locked_o   (locked_o)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clampk(input int v);
        return (v < K_MIN) ? K_MIN : (v > K_MAX) ? K_MAX : v;
    endfunction

    // One loop update with phase error err (cycles, positive = ref early).
    task automatic model_update(input int err);
        int mag;
        m_integ = clampk(m_integ + floor_div(err, 1 << KI_SHIFT));
        m_k     = clampk(m_integ + floor_div(err, 1 << KP_SHIFT));
        mag     = (err < 0) ? -err : err;
        if (mag <= LOCK_TOL) begin
            if (m_lock_run < LOCK_CNT) m_lock_run++;
        end else begin
            m_lock_run = 0;
        end
        m_locked = (m_lock_run == LOCK_CNT) ? 1 : 0;
    endtask

    task automatic model_reset();
        m_integ = K_INIT; m_k = K_INIT; m_lock_run = 0; m_locked = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge fpga_clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step(1);
        reset_i = 1'b0;
        step(2);
        model_reset();
    endtask

    // Rising edges on both inputs; skew > 0 means the reference leads by skew cycles.
    task automatic pair(input int skew);
        int tr, tf, last;
        tr   = (skew < 0) ? -skew : 0;
        tf   = (skew > 0) ? skew : 0;
        last = ((tr > tf) ? tr : tf) + 2;
        for (int t = 0; t <= last; t++) begin
            ref_clk_i = (t >= tr && t < tr + 2);
            fb_clk_i  = (t >= tf && t < tf + 2);
            @(negedge fpga_clk_i);
        end
        step(8);
        model_update(skew);
    endtask

    // Two rising edges on one input with none on the other: frequency error.
    task automatic double_edge(input bit use_ref, input int gap);
        logic lvl;
        for (int t = 0; t < gap + 2; t++) begin
            lvl = (t < 2) || (t >= gap && t < gap + 2);
            if (use_ref) ref_clk_i = lvl; else fb_clk_i = lvl;
            @(negedge fpga_clk_i);
        end
        ref_clk_i = 1'b0;
        fb_clk_i  = 1'b0;
        step(8);
        model_update(use_ref ? E_MAX : -E_MAX);
    endtask

    task automatic pulse_disable();
        enable_i = 1'b0;
        step(3);
        enable_i = 1'b1;
        step(2);
        m_lock_run = 0;
        m_locked   = 0;
    endtask

    // Assert reset between clock edges and check outputs without waiting for an edge.
    task automatic async_reset_check(input string tag);
        #2 reset_i = 1'b1;
        #1;
        check({tag, "_k"},      k_val_o,  K_INIT);
        check({tag, "_locked"}, locked_o, 0);
        check({tag, "_dco_en"}, dco_en_o, 0);
        @(negedge fpga_clk_i);
        reset_i = 1'b0;
        step(2);
        model_reset();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_k"},      k_val_o,  m_k);
        check({tag, "_locked"}, locked_o, m_locked);
    endtask

    initial begin
        int skew;

        // Reset state
        step(1);
        check("rst_k",      k_val_o,  K_INIT);
        check("rst_locked", locked_o, 0);
        check("rst_dco_en", dco_en_o, 0);
        reset_i = 1'b0;
        step(2);
        check("dco_en_on", dco_en_o, 1);

        // Reference leads by 8 cycles
        pair(8);
        check("ref_lead8_k", k_val_o, 11);
        check_model("ref_lead8");

        // Feedback leads by 8 cycles
        do_reset();
        pair(-8);
        check("fb_lead8_k", k_val_o, 5);
        check_model("fb_lead8");

        // Frequency error clamps high, then mid-run reset, then clamps low
        do_reset();
        double_edge(1'b1, 6);
        check("freq_hi_k", k_val_o, 15);
        check_model("freq_hi");
        async_reset_check("midrun_rst1");
        double_edge(1'b0, 6);
        check("freq_lo_k", k_val_o, 1);
        check_model("freq_lo");
        pulse_disable();

        // Randomised skews against the model
        for (int i = 0; i < 40; i++) begin
            skew = int'($urandom_range(0, 40)) - 20;
            pair(skew);
            check_model($sformatf("rand%0d_skew%0d", i, skew));
        end

        // Lock acquisition on coincident edges, loss on an out-of-tolerance update
        pulse_disable();
        for (int i = 1; i <= LOCK_CNT; i++) begin
            pair(0);
            check_model($sformatf("lock_upd%0d", i));
            if (i == LOCK_CNT - 1) check("lock_not_yet", locked_o, 0);
        end
        check("lock_16th", locked_o, 1);
        pair(5);
        check("lock_lost", locked_o, 0);
        check_model("lock_lost");

        // Disable while the reference is ahead: no update, DCO enable drops a cycle later
        ref_clk_i = 1'b1;
        step(2);
        ref_clk_i = 1'b0;
        step(3);
        enable_i = 1'b0;
        #1;
        check("dis_dco_en_before", dco_en_o, 1);
        step(1);
        check("dis_dco_en_after", dco_en_o, 0);
        fb_clk_i = 1'b1;
        step(2);
        fb_clk_i = 1'b0;
        step(8);
        m_lock_run = 0;
        m_locked   = 0;
        check_model("dis_hold");
        enable_i = 1'b1;
        step(2);
        pair(-3);
        check_model("reenable");

        // Final mid-run reset after activity
        pair(12);
        check_model("pre_rst2");
        async_reset_check("midrun_rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
